// File: rtl/mc_core_hs.sv
// Multicycle accumulator core: register file, datapath and control FSM behind a single
// req/ack memory port that tolerates any number of wait states.
module mc_core_hs #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [DATA_W-1:0] acc_dbg
);

    localparam int unsigned RW = $clog2(NREGS);

    localparam logic [3:0] OpLoad  = 4'b0000;
    localparam logic [3:0] OpStore = 4'b0001;
    localparam logic [3:0] OpJump  = 4'b0010;
    localparam logic [3:0] OpBrz   = 4'b0100;
    localparam logic [3:0] OpAlu   = 4'b1000;
    localparam logic [3:0] OpHalt  = 4'b1001;

    localparam logic [2:0] FnMovTo = 3'b000;
    localparam logic [2:0] FnMovFr = 3'b001;
    localparam logic [2:0] FnAdd   = 3'b010;
    localparam logic [2:0] FnSub   = 3'b011;
    localparam logic [2:0] FnAnd   = 3'b100;
    localparam logic [2:0] FnOr    = 3'b101;
    localparam logic [2:0] FnNot   = 3'b110;
    localparam logic [2:0] FnNop   = 3'b111;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StDecode,
        StMem,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] rf [NREGS];

    logic [3:0]        op;
    logic [ADDR_W-1:0] addr_f;
    logic [RW-1:0]     rn;
    logic [2:0]        func;
    logic              r0_zero;
    logic [DATA_W-1:0] alu_res;

    assign op      = ir[DATA_W-1 -: 4];
    assign addr_f  = ir[ADDR_W-1:0];
    assign rn      = ir[ADDR_W-1 -: RW];
    assign func    = ir[2:0];
    assign r0_zero = (rf[0] == '0);

    assign pc_dbg  = pc;
    assign acc_dbg = rf[0];

    always_comb begin
        alu_res = reg_a;
        case (func)
            FnMovTo: alu_res = reg_a;
            FnMovFr: alu_res = reg_b;
            FnAdd:   alu_res = reg_a + reg_b;
            FnSub:   alu_res = reg_a - reg_b;
            FnAnd:   alu_res = reg_a & reg_b;
            FnOr:    alu_res = reg_a | reg_b;
            FnNot:   alu_res = ~reg_a;
            default: alu_res = reg_a;
        endcase
    end

    // Port outputs are registered: each transition into FETCH/MEM loads the request it will
    // present, so address and direction stay frozen for as long as ack is withheld.
    // mem_wdata is a shadow of R0, updated in the same places R0 is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StBoot;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            alu_out   <= '0;
            for (int k = 0; k < NREGS; k++) rf[k] <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                StBoot: begin
                    state    <= StFetch;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                StFetch: begin
                    if (mem_ack) begin
                        ir      <= mem_rdata;
                        pc      <= pc + ADDR_W'(1);
                        mem_req <= 1'b0;
                        state   <= StDecode;
                    end
                end
                StDecode: begin
                    reg_a <= rf[0];
                    reg_b <= rf[rn];
                    case (op)
                        OpJump: begin
                            pc       <= addr_f;
                            state    <= StFetch;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= addr_f;
                        end
                        OpBrz: begin
                            state    <= StFetch;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            if (r0_zero) begin
                                pc       <= addr_f;
                                mem_addr <= addr_f;
                            end else begin
                                mem_addr <= pc;
                            end
                        end
                        OpLoad, OpStore: begin
                            state    <= StMem;
                            mem_req  <= 1'b1;
                            mem_we   <= (op == OpStore);
                            mem_addr <= addr_f;
                        end
                        OpAlu: begin
                            if (func == FnNop) begin
                                state    <= StFetch;
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= pc;
                            end else begin
                                state <= StExec;
                            end
                        end
                        OpHalt: begin
                            state  <= StHalt;
                            halted <= 1'b1;
                        end
                        default: begin
                            state   <= StHalt;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                StMem: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            rf[0]     <= mem_rdata;
                            mem_wdata <= mem_rdata;
                        end
                        // Request stays high: the next fetch follows back-to-back.
                        state    <= StFetch;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                StExec: begin
                    alu_out <= alu_res;
                    state   <= StWb;
                end
                StWb: begin
                    if (func == FnMovTo) begin
                        rf[rn] <= alu_out;
                        if (rn == '0) mem_wdata <= alu_out;
                    end else begin
                        rf[0]     <= alu_out;
                        mem_wdata <= alu_out;
                    end
                    state    <= StFetch;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                StHalt: begin
                    mem_req <= 1'b0;
                end
                default: begin
                    state   <= StHalt;
                    mem_req <= 1'b0;
                    halted  <= 1'b1;
                end
            endcase
        end
    end

endmodule
